// File: rtl/lcd_pkg.sv
// Shared definitions for the 8080-style LCD write path: bus width, RS encodings,
// sequencer state encoding and a small helper for sizing the phase counter.
package lcd_pkg;

  localparam int   LCD_DB_W    = 16;
  localparam logic LCD_RS_CMD  = 1'b0;
  localparam logic LCD_RS_DATA = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_OPEN
  } lcd_seq_state_t;

  function automatic int lcd_max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/lcd_write_sequencer.sv
// Turns valid/ready beats into RS/CS/WR/DB write cycles with programmable setup,
// strobe and hold phases; not-last beats keep CS low so pixel bursts stream.
module lcd_write_sequencer
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC = 1,
  parameter int PULSE_CYC = 2,
  parameter int HOLD_CYC  = 1
) (
  input  logic                clk,
  input  logic                in_reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_rs,
  input  logic [LCD_DB_W-1:0] req_data,
  input  logic                req_last,
  output logic                busy,
  output logic                out_rs,
  output logic                out_cs,
  output logic                out_wr,
  output logic [LCD_DB_W-1:0] out_db
);

  localparam int CNT_W = $clog2(lcd_max3(SETUP_CYC, PULSE_CYC, HOLD_CYC) + 1);

  lcd_seq_state_t      state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                last_q;
  logic                cs_q;
  logic                wr_q;
  logic                rs_q;
  logic [LCD_DB_W-1:0] db_q;

  logic setup_done;
  logic pulse_done;
  logic hold_done;
  logic accept;

  assign setup_done = (cnt_q == CNT_W'(SETUP_CYC - 1));
  assign pulse_done = (cnt_q == CNT_W'(PULSE_CYC - 1));
  assign hold_done  = (cnt_q == CNT_W'(HOLD_CYC - 1));

  // A new beat may start only from an idle/open bus or in the last hold cycle of a burst beat.
  assign req_ready = (state_q == ST_IDLE) || (state_q == ST_OPEN) ||
                     ((state_q == ST_HOLD) && hold_done && !last_q);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = req_valid && req_ready;

  // NOTE: the bus pins are reset asynchronously with the state, so a write in
  // progress is abandoned at once and WR/CS never linger low during reset.
  always_ff @(posedge clk or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      last_q  <= 1'b1;
      cs_q    <= 1'b1;
      wr_q    <= 1'b1;
      rs_q    <= LCD_RS_CMD;
      db_q    <= '0;
    end else if (accept) begin
      // RS/DB only ever change here, so they are stable around every WR pulse.
      state_q <= ST_SETUP;
      cnt_q   <= '0;
      last_q  <= req_last;
      rs_q    <= req_rs;
      db_q    <= req_data;
      cs_q    <= 1'b0;
      wr_q    <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch reads the
      // pre-edge values of cnt_q/last_q regardless of statement order.
      case (state_q)
        ST_SETUP: begin
          if (setup_done) begin
            state_q <= ST_STROBE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_STROBE: begin
          if (pulse_done) begin
            state_q <= ST_HOLD;
            cnt_q   <= '0;
            wr_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_HOLD: begin
          if (hold_done) begin
            state_q <= last_q ? ST_IDLE : ST_OPEN;
            cnt_q   <= '0;
            cs_q    <= last_q;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_cs = cs_q;
  assign out_wr = wr_q;
  assign out_rs = rs_q;
  assign out_db = db_q;

endmodule

// File: tb/tb_lcd_write_sequencer.sv
// Scoreboard bench for lcd_write_sequencer: two instances (default timing and
// 2/3/2 timing) driven by directed and random beats against a timeline model.
module tb_lcd_write_sequencer;
  import lcd_pkg::*;

  localparam int NL = 2;

  function automatic int s_of(input int k); return (k == 0) ? 1 : 2; endfunction
  function automatic int p_of(input int k); return (k == 0) ? 2 : 3; endfunction
  function automatic int h_of(input int k); return (k == 0) ? 1 : 2; endfunction

  typedef struct {
    logic        rs;
    logic [15:0] data;
    logic        last;
    int          gap;
  } stim_t;

  typedef struct {
    logic        rs;
    logic [15:0] data;
    int          fall_edge;
  } exp_t;

  logic                clk = 1'b0;
  logic                in_reset = 1'b0;
  logic [NL-1:0]       req_valid = '0;
  logic [NL-1:0]       req_rs = '0;
  logic [NL-1:0]       req_last = '0;
  logic [NL-1:0]       req_ready, busy, out_rs, out_cs, out_wr;
  logic [LCD_DB_W-1:0] req_data [NL];
  logic [LCD_DB_W-1:0] out_db [NL];

  lcd_write_sequencer #(.SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)) dut0 (
    .clk(clk), .in_reset(in_reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_rs(req_rs[0]),
    .req_data(req_data[0]), .req_last(req_last[0]), .busy(busy[0]),
    .out_rs(out_rs[0]), .out_cs(out_cs[0]), .out_wr(out_wr[0]), .out_db(out_db[0])
  );

  lcd_write_sequencer #(.SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)) dut1 (
    .clk(clk), .in_reset(in_reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_rs(req_rs[1]),
    .req_data(req_data[1]), .req_last(req_last[1]), .busy(busy[1]),
    .out_rs(out_rs[1]), .out_cs(out_cs[1]), .out_wr(out_wr[1]), .out_db(out_db[1])
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  int checks = 0;
  int failures = 0;

  // Timeline model: each accepted beat at edge T owns edges T..T+S+P+H-1.
  stim_t stim_q [NL][$];
  exp_t  sb_q   [NL][$];
  int    hold_end   [NL];
  logic  last_prev  [NL];
  int    cs_start   [NL];
  int    cs_rel     [NL];
  bit    burst_open [NL];
  bit    offering   [NL];

  bit    prev_wr [NL];
  int    low_cnt [NL];
  exp_t  cur     [NL];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_cnt, act, exp);
    end
  endtask

  task automatic reset_model();
    for (int k = 0; k < NL; k++) begin
      hold_end[k]   = edge_cnt;
      last_prev[k]  = 1'b1;
      cs_start[k]   = 0;
      cs_rel[k]     = 0;
      burst_open[k] = 1'b0;
      offering[k]   = 1'b0;
      req_valid[k]  = 1'b0;
      sb_q[k].delete();
      stim_q[k].delete();
    end
  endtask

  // One cycle of stimulus: drive at the falling edge, predict what the next rising edge accepts.
  task automatic step();
    stim_t it;
    exp_t  ex;
    int    e1;
    bit    exp_rdy;
    @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      e1 = edge_cnt + 1;
      if (!offering[k]) begin
        req_valid[k] = 1'b0;
        req_data[k]  = 16'($urandom);
        req_rs[k]    = 1'($urandom);
        req_last[k]  = 1'($urandom);
        if (stim_q[k].size() > 0) begin
          it = stim_q[k][0];
          if (it.gap > 0) begin
            it.gap--;
            stim_q[k][0] = it;
          end else begin
            it = stim_q[k].pop_front();
            req_valid[k] = 1'b1;
            req_rs[k]    = it.rs;
            req_data[k]  = it.data;
            req_last[k]  = it.last;
            offering[k]  = 1'b1;
          end
        end
      end
      exp_rdy = (e1 > hold_end[k]) || ((e1 == hold_end[k]) && !last_prev[k]);
      check($sformatf("req_ready[%0d]", k), req_ready[k], exp_rdy);
      if (req_valid[k] && exp_rdy) begin
        ex.rs = req_rs[k];
        ex.data = req_data[k];
        ex.fall_edge = e1 + s_of(k);
        sb_q[k].push_back(ex);
        if (!burst_open[k]) begin
          cs_start[k]   = e1;
          burst_open[k] = 1'b1;
        end
        hold_end[k]  = e1 + s_of(k) + p_of(k) + h_of(k);
        last_prev[k] = req_last[k];
        if (req_last[k]) begin
          burst_open[k] = 1'b0;
          cs_rel[k]     = hold_end[k];
        end
        offering[k] = 1'b0;
      end
    end
  endtask

  task automatic run_drain(input string name, input int budget);
    int n;
    bit done;
    n = 0;
    do begin
      step();
      n++;
      done = 1'b1;
      for (int k = 0; k < NL; k++)
        if (stim_q[k].size() != 0 || offering[k] || sb_q[k].size() != 0 ||
            edge_cnt < hold_end[k] + 2)
          done = 1'b0;
    end while (!done && n < budget);
    check({name, "_drained"}, done, 1);
  endtask

  task automatic push_beat(input logic rs, input logic [15:0] data, input logic last, input int gap);
    stim_t it;
    it.rs = rs;
    it.data = data;
    it.last = last;
    it.gap = gap;
    for (int k = 0; k < NL; k++) stim_q[k].push_back(it);
  endtask

  // Monitor: checks CS/busy every cycle and pops the scoreboard on each WR fall.
  always @(posedge clk) begin
    int   x;
    bit   exp_low;
    #1;
    for (int k = 0; k < NL; k++) begin
      if (!in_reset) begin
        prev_wr[k] = 1'b1;
        low_cnt[k] = 0;
      end else begin
        x = edge_cnt;
        exp_low = (x >= cs_start[k]) && (burst_open[k] || (x < cs_rel[k]));
        check($sformatf("out_cs[%0d]", k), out_cs[k], !exp_low);
        check($sformatf("busy[%0d]", k), busy[k], !(last_prev[k] && (x >= hold_end[k])));
        if (prev_wr[k] && !out_wr[k]) begin
          check($sformatf("wr_fall_pending[%0d]", k), sb_q[k].size(), 1);
          if (sb_q[k].size() > 0) begin
            cur[k] = sb_q[k].pop_front();
            check($sformatf("wr_fall_edge[%0d]", k), x, cur[k].fall_edge);
            check($sformatf("out_rs[%0d]", k), out_rs[k], cur[k].rs);
            check($sformatf("out_db[%0d]", k), out_db[k], cur[k].data);
          end
          low_cnt[k] = 1;
        end else if (!out_wr[k]) begin
          low_cnt[k]++;
          check($sformatf("db_stable[%0d]", k), out_db[k], cur[k].data);
          check($sformatf("rs_stable[%0d]", k), out_rs[k], cur[k].rs);
        end else if (!prev_wr[k]) begin
          check($sformatf("wr_width[%0d]", k), low_cnt[k], p_of(k));
        end
        prev_wr[k] = out_wr[k];
      end
    end
  end

  initial begin
    int n;
    for (int k = 0; k < NL; k++) begin
      req_data[k] = '0;
      prev_wr[k]  = 1'b1;
      low_cnt[k]  = 0;
    end
    reset_model();
    in_reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < NL; k++) begin
      check($sformatf("rst_cs[%0d]", k), out_cs[k], 1);
      check($sformatf("rst_wr[%0d]", k), out_wr[k], 1);
      check($sformatf("rst_rs[%0d]", k), out_rs[k], 0);
      check($sformatf("rst_db[%0d]", k), out_db[k], 0);
      check($sformatf("rst_busy[%0d]", k), busy[k], 0);
    end
    reset_model();
    in_reset = 1'b1;

    // Single command, then an 8-pixel burst, then a stalled burst ending in a command.
    push_beat(LCD_RS_CMD, 16'h0022, 1'b1, 0);
    for (int i = 0; i < 8; i++)
      push_beat(LCD_RS_DATA, 16'hF800 + 16'(i), (i == 7), (i == 0) ? 3 : 0);
    push_beat(LCD_RS_DATA, 16'h1234, 1'b0, 2);
    push_beat(LCD_RS_DATA, 16'h5678, 1'b1, 9);
    push_beat(LCD_RS_CMD, 16'h002C, 1'b1, 2);
    run_drain("directed", 400);

    // Random beats with random gaps; the final beat always closes its burst.
    for (int k = 0; k < NL; k++) begin
      for (int i = 0; i < 60; i++) begin
        stim_t it;
        it.rs   = 1'($urandom);
        it.data = 16'($urandom);
        it.last = (i == 59) ? 1'b1 : ($urandom_range(0, 3) == 0);
        it.gap  = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 8) : 0;
        stim_q[k].push_back(it);
      end
    end
    run_drain("random", 3000);

    // Reset landing while lane 0 drives WR low.
    push_beat(LCD_RS_DATA, 16'hBEEF, 1'b1, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (out_wr[0] !== 1'b0 && n < 50);
    check("strobe_reached", out_wr[0], 0);
    #2 in_reset = 1'b0;
    #1;
    for (int k = 0; k < NL; k++) begin
      check($sformatf("async_rst_wr[%0d]", k), out_wr[k], 1);
      check($sformatf("async_rst_cs[%0d]", k), out_cs[k], 1);
    end
    reset_model();
    repeat (2) @(negedge clk);
    for (int k = 0; k < NL; k++)
      check($sformatf("async_rst_busy[%0d]", k), busy[k], 0);
    reset_model();
    in_reset = 1'b1;

    push_beat(LCD_RS_CMD, 16'h0036, 1'b1, 0);
    push_beat(LCD_RS_DATA, 16'h00A5, 1'b0, 1);
    push_beat(LCD_RS_DATA, 16'h5A00, 1'b1, 0);
    run_drain("post_reset", 200);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
